// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer for the 16-bit ALU datapath.
// Fetches over a ready handshake, decodes the 5-bit opcode and walks
// FETCH/DECODE/EXEC/MEM/WB, driving register-file, memory and PC strobes.
module mc_control_fsm #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [15:0] instr_rdata,
    output logic        ir_we,
    output logic [4:0]  alu_control,
    output logic        alu_src_imm,
    input  logic        branch_gate,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic        dmem_re,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } state_t;

    localparam logic [7:0] LP_LIMIT = 8'(WAIT_LIMIT);
    localparam logic [4:0] OP_LOAD  = 5'd14;
    localparam logic [4:0] OP_STORE = 5'd15;
    localparam logic [4:0] OP_JALR  = 5'd20;

    state_t     r_state;
    logic [4:0] r_op;
    logic [7:0] r_cnt;
    logic       r_illegal;
    logic       r_bus_err;

    logic [7:0] w_cnt_inc;
    logic       w_timeout;
    logic       w_alu_phase;

    assign w_cnt_inc   = r_cnt + 8'd1;
    // The wait that would bring the count to the limit is the one that traps.
    assign w_timeout   = (w_cnt_inc == LP_LIMIT);
    assign w_alu_phase = (r_state == StExec) || (r_state == StMem) || (r_state == StWb);

    // State, opcode, wait counter and sticky trap flags; counter clears on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StFetch;
            r_op      <= 5'd0;
            r_cnt     <= 8'd0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                StFetch: begin
                    if (imem_ready) begin
                        r_op    <= instr_rdata[15:11];
                        r_state <= StDecode;
                        r_cnt   <= 8'd0;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_state   <= StTrap;
                        r_cnt     <= 8'd0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StDecode: begin
                    r_cnt <= 8'd0;
                    if (r_op == 5'd0) begin
                        r_state <= StFetch;
                    end else if (r_op > OP_JALR) begin
                        r_illegal <= 1'b1;
                        r_state   <= StTrap;
                    end else begin
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    r_cnt <= 8'd0;
                    if (r_op <= 5'd13) begin
                        r_state <= StWb;
                    end else if (r_op <= OP_STORE) begin
                        r_state <= StMem;
                    end else begin
                        r_state <= StFetch;
                    end
                end
                StMem: begin
                    if (dmem_ready) begin
                        r_cnt   <= 8'd0;
                        r_state <= (r_op == OP_STORE) ? StFetch : StWb;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_state   <= StTrap;
                        r_cnt     <= 8'd0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StWb: begin
                    r_cnt   <= 8'd0;
                    r_state <= StFetch;
                end
                StTrap: begin
                    r_state <= StTrap;
                end
                default: begin
                    r_cnt   <= 8'd0;
                    r_state <= StFetch;
                end
            endcase
        end
    end

    // Strobes decoded from state, opcode and the handshake inputs.
    always_comb begin
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        alu_control = 5'd0;
        alu_src_imm = 1'b0;
        rf_we       = 1'b0;
        rf_wsel     = 2'd0;
        dmem_re     = 1'b0;
        dmem_we     = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;

        if (w_alu_phase) begin
            // JALR borrows ADD so the ALU forms rs1+imm as the jump target.
            alu_control = (r_op == OP_JALR) ? 5'd1 : r_op;
            alu_src_imm = ((r_op >= 5'd8) && (r_op <= OP_STORE)) || (r_op == OP_JALR);
        end

        case (r_state)
            StFetch: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            StDecode: begin
                pc_we = (r_op == 5'd0);
            end
            StExec: begin
                if ((r_op >= 5'd16) && (r_op <= 5'd19)) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_gate ? 2'd1 : 2'd0;
                end else if (r_op == OP_JALR) begin
                    rf_we   = 1'b1;
                    rf_wsel = 2'd2;
                    pc_we   = 1'b1;
                    pc_sel  = 2'd2;
                end
            end
            StMem: begin
                dmem_re = (r_op == OP_LOAD);
                dmem_we = (r_op == OP_STORE);
                pc_we   = (r_op == OP_STORE) && dmem_ready;
            end
            StWb: begin
                rf_we   = 1'b1;
                rf_wsel = (r_op == OP_LOAD) ? 2'd1 : 2'd0;
                pc_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal   = r_illegal;
    assign bus_err   = r_bus_err;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: each cycle compares the full output
// bundle against a hand-written expected vector.
module tb_mc_control_fsm;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic        imem_ready;
    logic [15:0] instr_rdata;
    logic        ir_we;
    logic [4:0]  alu_control;
    logic        alu_src_imm;
    logic        branch_gate;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic        dmem_re;
    logic        dmem_we;
    logic        dmem_ready;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        illegal;
    logic        bus_err;
    logic [2:0]  state_dbg;

    int n_checks;
    int n_fail;

    mc_control_fsm #(.WAIT_LIMIT(15)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .instr_rdata(instr_rdata),
        .ir_we      (ir_we),
        .alu_control(alu_control),
        .alu_src_imm(alu_src_imm),
        .branch_gate(branch_gate),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundle: req, ir_we, alu, imm, rf_we, wsel, re, we, pc_we, pc_sel, ill, berr, state
    logic [20:0] w_obs;
    assign w_obs = {imem_req, ir_we, alu_control, alu_src_imm, rf_we, rf_wsel,
                    dmem_re, dmem_we, pc_we, pc_sel, illegal, bus_err, state_dbg};

    function automatic logic [20:0] pk(input logic req, input logic irw, input logic [4:0] alu,
                                       input logic imm, input logic rfwe, input logic [1:0] wsel,
                                       input logic re, input logic we, input logic pcwe,
                                       input logic [1:0] psel, input logic ill, input logic be,
                                       input logic [2:0] st);
        return {req, irw, alu, imm, rfwe, wsel, re, we, pcwe, psel, ill, be, st};
    endfunction

    task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    // Check the current cycle's outputs, then advance one clock.
    task automatic tick(input string tag, input logic [20:0] exp);
        #1;
        chk(tag, w_obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [20:0] EXP_FETCH_IDLE = 21'h100000; // imem_req only, state FETCH

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        imem_ready  = 1'b0;
        instr_rdata = 16'h0000;
        branch_gate = 1'b0;
        dmem_ready  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state: only imem_req high.
        #1;
        chk("reset", w_obs, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));

        // ADD 0x0800: F D E WB.
        imem_ready  = 1'b1;
        instr_rdata = 16'h0800;
        tick("add_fetch",  pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        tick("add_decode", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
        tick("add_exec",   pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        tick("add_wb",     pk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 3'd4));

        // LOAD 0x7000 with three wait cycles in MEM.
        instr_rdata = 16'h7000;
        tick("ld_fetch",  pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        imem_ready = 1'b0;
        tick("ld_decode", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
        tick("ld_exec",   pk(0, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        for (int i = 0; i < 3; i++) begin
            tick("ld_mem_wait", pk(0, 0, 14, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3'd3));
        end
        dmem_ready = 1'b1;
        tick("ld_mem_done", pk(0, 0, 14, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3'd3));
        dmem_ready = 1'b0;
        tick("ld_wb",       pk(0, 0, 14, 1, 1, 1, 0, 0, 1, 0, 0, 0, 3'd4));
        tick("ld_back",     EXP_FETCH_IDLE);

        // STORE 0x7800 zero-wait: PC advances in MEM.
        imem_ready  = 1'b1;
        instr_rdata = 16'h7800;
        tick("st_fetch",  pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        imem_ready = 1'b0;
        tick("st_decode", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
        tick("st_exec",   pk(0, 0, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        dmem_ready = 1'b1;
        tick("st_mem",    pk(0, 0, 15, 1, 0, 0, 0, 1, 1, 0, 0, 0, 3'd3));
        dmem_ready = 1'b0;

        // BEQ 0x8000 taken then not taken.
        for (int t = 1; t >= 0; t--) begin
            imem_ready  = 1'b1;
            instr_rdata = 16'h8000;
            branch_gate = 1'(t);
            tick("beq_fetch",  pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
            imem_ready = 1'b0;
            tick("beq_decode", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
            tick("beq_exec",   pk(0, 0, 16, 0, 0, 0, 0, 0, 1, 2'(t), 0, 0, 3'd2));
        end
        branch_gate = 1'b0;

        // JALR 0xA000.
        imem_ready  = 1'b1;
        instr_rdata = 16'hA000;
        tick("jalr_fetch",  pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        imem_ready = 1'b0;
        tick("jalr_decode", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
        tick("jalr_exec",   pk(0, 0, 1, 1, 1, 2, 0, 0, 1, 2, 0, 0, 3'd2));
        tick("jalr_back",   EXP_FETCH_IDLE);

        // NOP 0x0000: PC advances from DECODE.
        imem_ready  = 1'b1;
        instr_rdata = 16'h0000;
        tick("nop_fetch",  pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        imem_ready = 1'b0;
        tick("nop_decode", pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'd1));

        // Illegal op 23 traps and stays sticky until reset.
        imem_ready  = 1'b1;
        instr_rdata = 16'hB800;
        tick("ill_fetch",  pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        tick("ill_decode", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
        tick("ill_trap0",  pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd7));
        tick("ill_trap1",  pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'd7));
        imem_ready = 1'b0;
        do_reset();
        tick("ill_reset",  EXP_FETCH_IDLE);
        do_reset();

        // Fetch timeout: 15 cycles without ready, then TRAP with bus_err.
        for (int i = 0; i < 15; i++) begin
            tick("to_fetch", EXP_FETCH_IDLE);
        end
        #1;
        chk("to_trap", w_obs, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd7));
        do_reset();

        // Ready arriving in the limit cycle wins.
        for (int i = 0; i < 14; i++) begin
            tick("lim_fetch", EXP_FETCH_IDLE);
        end
        imem_ready  = 1'b1;
        instr_rdata = 16'h0800;
        tick("lim_ready",  pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        imem_ready = 1'b0;
        tick("lim_decode", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));

        // Reset has priority mid-MEM.
        tick("rm_exec",    pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        tick("rm_wb",      pk(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 3'd4));
        imem_ready  = 1'b1;
        instr_rdata = 16'h7000;
        tick("rm_fetch",   pk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        imem_ready = 1'b0;
        tick("rm_decode",  pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
        tick("rm_exec2",   pk(0, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        tick("rm_mem",     pk(0, 0, 14, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3'd3));
        do_reset();
        tick("rm_reset",   EXP_FETCH_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
